// File: rtl/mem_wb_if.sv
// mem_wb_if: bundle of the stage-boundary signals used by mem_wb_pipe.
//
// Parameters:
//   DATA_W : data bundle width
//   CTRL_W : control bundle width
//   OCC_W  : occupancy count width
//
// Signals (driven by the upstream stage = master):
//   stall, flush, valid_in, data_in[DATA_W], ctrl_in[CTRL_W]
// Signals (driven by the pipe = slave):
//   valid_out, data_out[DATA_W], ctrl_out[CTRL_W], occ_out[OCC_W]
//   stall_cnt[32], flush_cnt[32]  (only when MEM_WB_PERF_EN is defined)
interface mem_wb_if #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2,
    parameter int OCC_W  = 3
);
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [OCC_W-1:0]  occ_out;
`ifdef MEM_WB_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
        output stall, flush, valid_in, data_in, ctrl_in,
`ifdef MEM_WB_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        input  valid_out, data_out, ctrl_out, occ_out
    );

    modport slave (
        input  stall, flush, valid_in, data_in, ctrl_in,
`ifdef MEM_WB_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output valid_out, data_out, ctrl_out, occ_out
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: parametrised inter-stage pipeline register (MEM->WB and similar).
// Carries a data and a control bundle through STAGES register slices with a
// per-slice valid bit, stall (hold), flush (bubble insert) and an occupancy
// count. Control bits are zero in any slice that holds a bubble.
//
// Optional feature macro: MEM_WB_PERF_EN adds saturating 32-bit stall/flush
// cycle counters (bus.stall_cnt, bus.flush_cnt).
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : mem_wb_if.slave (stall, flush, valid_in, data_in, ctrl_in in;
//           valid_out, data_out, ctrl_out, occ_out [, stall_cnt, flush_cnt] out)
module mem_wb_pipe #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2,
    parameter int STAGES = 1,
    parameter int OCC_W  = 3
) (
    input  logic     clk,
    input  logic     reset,
    mem_wb_if.slave  bus
);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("mem_wb_pipe: STAGES must be in 1..4");
        end
        if ((1 << OCC_W) <= STAGES) begin : g_bad_occ_w
            $error("mem_wb_pipe: OCC_W too narrow for STAGES");
        end
    endgenerate

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(vec[i]);
        end
        return cnt;
    endfunction

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [CTRL_W-1:0] c [STAGES];
    logic [DATA_W-1:0] d [STAGES];
    logic [OCC_W-1:0]  occ;

    // Next valid vector is computed once so occupancy can be registered on the
    // same edge as the valid bits without a separate counter.
    always_comb begin
        v_next = v;
        if (!reset || bus.flush) begin
            v_next = '0;
        end else if (!bus.stall) begin
            v_next[0] = bus.valid_in;
            for (int k = 1; k < STAGES; k++) begin
                v_next[k] = v[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        v   <= v_next;
        occ <= popcount(v_next);
    end

    // Flush clears control only; data is left in place since it is
    // meaningless without its valid bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                c[k] <= '0;
                d[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 0; k < STAGES; k++) begin
                c[k] <= '0;
            end
        end else if (!bus.stall) begin
            c[0] <= bus.valid_in ? bus.ctrl_in : '0;
            d[0] <= bus.data_in;
            for (int k = 1; k < STAGES; k++) begin
                c[k] <= c[k-1];
                d[k] <= d[k-1];
            end
        end
    end

    assign bus.valid_out = v[STAGES-1];
    assign bus.ctrl_out  = c[STAGES-1];
    assign bus.data_out  = d[STAGES-1];
    assign bus.occ_out   = occ;

`ifdef MEM_WB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // A cycle with both stall and flush counts only as a flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (bus.flush) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
        end else if (bus.stall) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
    assign bus.flush_cnt = flush_cnt_r;
`endif

endmodule
